uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 LED receiver. It adds the following over that block:
- configurable baud divisor, data width, parity and stop-bit count;
- input synchronisation and majority-vote sampling;
- false-start rejection;
- parity and framing error reporting;
- a valid/ready output handshake with overrun detection.

It sits between the board RX pin and consumer logic (LED register, command decoder), all in the single system clock domain.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_sampler.sv | 83 ++++++++
 rtl/uart_rx_param.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receiver state encoding, default divisor and a parity-check helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // 100 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // xor_all is the XOR of every data bit and the received parity bit.
    // Even parity expects it to be 0, odd parity expects it to be 1.
    function automatic logic parity_mismatch(input int mode, input logic xor_all);
        return (mode == PARITY_ODD) ? ~xor_all : xor_all;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Front end of the receiver: two-flop synchroniser on the raw pin, falling
// edge detect, free-running bit timer and a three-tap majority vote around
// mid-bit. The vote result is presented combinationally on the commit tick.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic timer_clear,
    output logic rxs,
    output logic start_edge,
    output logic sample_strobe,
    output logic sample_bit,
    output logic bit_end
);

    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam logic [TW-1:0] LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] COMMIT = TW'(MID + 1);

    logic [1:0]    sync_reg;
    logic          prev_reg;
    logic [TW-1:0] timer_reg;
    logic [TW-1:0] timer_next;
    logic [1:0]    vote_reg;

    assign rxs           = sync_reg[1];
    assign start_edge    = prev_reg & ~rxs;
    assign bit_end       = (timer_reg == LAST);
    assign sample_strobe = (timer_reg == COMMIT);
    // Third tap is the live synchronised value at MID+1
    assign sample_bit    = (vote_reg[0] & vote_reg[1]) |
                           (vote_reg[0] & rxs) |
                           (vote_reg[1] & rxs);

    // Synchroniser and edge-history flops idle high so reset never looks like a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 2'b11;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], rx};
            prev_reg <= sync_reg[1];
        end
    end

    // Bit timer wraps every CLKS_PER_BIT clocks; the FSM clears it to realign
    always_comb begin
        timer_next = timer_reg + TW'(1);
        if (timer_clear || bit_end) begin
            timer_next = '0;
        end
    end

    // Bit timer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_next;
        end
    end

    // Capture the first two vote taps at MID-1 and MID
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vote
            localparam logic [TW-1:0] TAP = TW'(MID - 1 + gi);
            // Hold the tap value until the next bit period overwrites it
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vote_reg[gi] <= 1'b1;
                end else if (timer_reg == TAP) begin
                    vote_reg[gi] <= rxs;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, LSB-first shift register, parity
// and framing checks, and a valid/ready output register with overrun flag.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    rx_state_t            state_reg;
    rx_state_t            state_next;
    logic [3:0]           bit_cnt_reg;
    logic [3:0]           bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 frame_perr_reg;
    logic                 frame_perr_next;

    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg;
    logic                 perr_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;

    logic timer_clear;
    logic deliver;
    logic frame_fail;
    logic rxs;
    logic start_edge;
    logic sample_strobe;
    logic sample_bit;
    logic bit_end;

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .timer_clear  (timer_clear),
        .rxs          (rxs),
        .start_edge   (start_edge),
        .sample_strobe(sample_strobe),
        .sample_bit   (sample_bit),
        .bit_end      (bit_end)
    );

    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign parity_err = perr_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

    // Frame state, bit counter, shift register and per-frame parity result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            frame_perr_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            frame_perr_reg <= frame_perr_next;
        end
    end

    // Next-state logic; transitions to the next field happen at bit_end so
    // the timer stays aligned, while stop-bit decisions are made at commit
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        frame_perr_next = frame_perr_reg;
        timer_clear     = 1'b0;
        deliver         = 1'b0;
        frame_fail      = 1'b0;
        case (state_reg)
            IDLE: begin
                // Hold the timer at zero so it starts counting on entry to START
                timer_clear     = 1'b1;
                bit_cnt_next    = '0;
                frame_perr_next = 1'b0;
                if (start_edge) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample_strobe && sample_bit) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (sample_strobe) begin
                    shift_next   = {sample_bit, shift_reg[DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
                if (bit_end && (bit_cnt_reg == 4'(DATA_BITS))) begin
                    bit_cnt_next = '0;
                    state_next   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample_strobe) begin
                    frame_perr_next = parity_mismatch(PARITY_MODE, (^shift_reg) ^ sample_bit);
                end
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample_strobe) begin
                    if (!sample_bit) begin
                        frame_fail  = 1'b1;
                        timer_clear = 1'b1;
                        state_next  = BREAK;
                    end else if (bit_cnt_reg == 4'(STOP_BITS - 1)) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            BREAK: begin
                // Any low sample restarts the full high bit period
                if (!rxs) begin
                    timer_clear = 1'b1;
                end else if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output word register with valid/ready handshake and one-clock status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            perr_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= frame_fail;
            overrun_reg   <= 1'b0;
            if (deliver) begin
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg  <= shift_reg;
                    perr_reg     <= frame_perr_reg;
                    rx_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7O2) driven one
// at a time. The stimulus side computes each frame's expected outcome from
// the protocol rules and queues it; a monitor pops and compares whenever a
// word is handed over on valid & ready.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] rx = 3'b111;
    logic [2:0] rdy = 3'b111;
    logic [2:0] vld, perr, ferr, ovr, bsy;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [8:0] dw [3];

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .rx(rx[0]), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0]));

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .rx(rx[1]), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1]));

    uart_rx_param #(.CLKS_PER_BIT(10), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .rx(rx[2]), .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2]));

    assign dw[0] = {1'b0, d0};
    assign dw[1] = {1'b0, d1};
    assign dw[2] = {2'b00, d2};

    function automatic int cfg_c(input int i);
        return (i == 2) ? 10 : 16;
    endfunction
    function automatic int cfg_d(input int i);
        return (i == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_p(input int i);
        return i;
    endfunction
    function automatic int cfg_s(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    // Expected words: {instance[1:0], parity_err, data[8:0]}
    logic [11:0] exp_q [$];
    int exp_fe [3] = '{0, 0, 0};
    int exp_ov [3] = '{0, 0, 0};
    bit pending [3] = '{0, 0, 0};

    int fe_cnt [3] = '{0, 0, 0};
    int ov_cnt [3] = '{0, 0, 0};
    int vhigh_cnt [3] = '{0, 0, 0};
    int rise_cyc [3] = '{0, 0, 0};
    logic [2:0] vld_prev = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: count status pulses and score each handed-over word
    always @(negedge clk) begin
        logic [11:0] e;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                if (ferr[i]) fe_cnt[i]++;
                if (ovr[i]) ov_cnt[i]++;
                if (vld[i]) vhigh_cnt[i]++;
                if (vld[i] && !vld_prev[i]) rise_cyc[i] = cyc;
                if (vld[i] && rdy[i]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL inst%0d_unexpected_word actual=%0h expected=none", i, dw[i]);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("inst%0d_word_source", i), 32'(i), 32'(e[11:10]));
                        check($sformatf("inst%0d_rx_data", i), 32'(dw[i]), 32'(e[8:0]));
                        check($sformatf("inst%0d_parity_err", i), 32'(perr[i]), 32'(e[9]));
                    end
                end
            end
        end
        vld_prev = vld;
    end

    task automatic drive_bit(input int i, input logic v, input int n);
        rx[i] = v;
        repeat (n) @(negedge clk);
    endtask

    // Build one frame from the protocol rules, record its expected outcome, drive it
    task automatic send_frame(input int i, input logic [8:0] data, input bit pflip, input bit sbad);
        int c, d, p, s;
        logic [8:0] w;
        logic pb;
        logic pe;
        c = cfg_c(i); d = cfg_d(i); p = cfg_p(i); s = cfg_s(i);
        w = data & ((9'd1 << d) - 9'd1);
        pb = ^w;
        if (p == 2) pb = ~pb;
        pb = pb ^ pflip;
        pe = (p != 0) && pflip;
        if (sbad) begin
            exp_fe[i]++;
        end else if (rdy[i]) begin
            exp_q.push_back({2'(i), pe, w});
        end else if (pending[i]) begin
            exp_ov[i]++;
        end else begin
            exp_q.push_back({2'(i), pe, w});
            pending[i] = 1'b1;
        end
        $display("send inst%0d data=%0h pflip=%0d stop_bad=%0d", i, w, pflip, sbad);
        @(negedge clk);
        start_cyc = cyc;
        drive_bit(i, 1'b0, c);
        for (int b = 0; b < d; b++) drive_bit(i, w[b], c);
        if (p != 0) drive_bit(i, pb, c);
        for (int b = 0; b < s; b++) drive_bit(i, !sbad, c);
        if (sbad) begin
            drive_bit(i, 1'b0, 40);
            drive_bit(i, 1'b1, 2 * c);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_inst%0d_frame_err_pulses", tag, i), 32'(fe_cnt[i]), 32'(exp_fe[i]));
            check($sformatf("%s_inst%0d_overrun_pulses", tag, i), 32'(ov_cnt[i]), 32'(exp_ov[i]));
        end
    endtask

    task automatic reset_abort(input int i, input logic [8:0] resend);
        int c;
        c = cfg_c(i);
        @(negedge clk);
        drive_bit(i, 1'b0, c);
        drive_bit(i, 1'b1, 3 * c + c / 2);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_inst%0d_outputs", k),
                  {23'(dw[k]), vld[k], perr[k], ferr[k], ovr[k], bsy[k]}, 32'd0);
        end
        @(negedge clk);
        rx[i] = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3 * c) @(negedge clk);
        send_frame(i, resend, 1'b0, 1'b0);
        wait_drain($sformatf("rst_inst%0d_resend_drained", i));
        check_counts("after_reset");
    endtask

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vsnap;
        bit saw_busy;
        logic [8:0] rd;
        bit pf, sb;

        // Reset state, checked while reset is held
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_inst%0d_outputs", k),
                  {23'(dw[k]), vld[k], perr[k], ferr[k], ovr[k], bsy[k]}, 32'd0);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 1: plain 8N1 word, single-cycle valid and latency window
        vsnap = vhigh_cnt[0];
        send_frame(0, 9'h0A5, 1'b0, 1'b0);
        wait_drain("t1_drained");
        repeat (4) @(negedge clk);
        check("t1_valid_cycles", 32'(vhigh_cnt[0] - vsnap), 32'd1);
        check("t1_latency_in_window",
              32'((rise_cyc[0] - start_cyc >= 9 * 16 + 8 + 2) && (rise_cyc[0] - start_cyc <= 9 * 16 + 8 + 6)),
              32'd1);
        check_counts("t1");

        // 2: short glitch is rejected as a false start
        vsnap = vhigh_cnt[0];
        saw_busy = 1'b0;
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx[0] = 1'b1;
        repeat (48) begin
            @(negedge clk);
            if (bsy[0]) saw_busy = 1'b1;
        end
        check("t2_busy_seen", 32'(saw_busy), 32'd1);
        check("t2_busy_idle", 32'(bsy[0]), 32'd0);
        check("t2_no_valid", 32'(vhigh_cnt[0] - vsnap), 32'd0);
        check_counts("t2");

        // 3: even parity, wrong then right parity bit
        send_frame(1, 9'h03C, 1'b1, 1'b0);
        send_frame(1, 9'h03C, 1'b0, 1'b0);
        wait_drain("t3_drained");

        // 4: framing error with a long break, then a clean word
        vsnap = vhigh_cnt[0];
        send_frame(0, 9'h055, 1'b0, 1'b1);
        check("t4_no_valid", 32'(vhigh_cnt[0] - vsnap), 32'd0);
        check_counts("t4");
        send_frame(0, 9'h012, 1'b0, 1'b0);
        wait_drain("t4_drained");

        // 5: consumer stalled, second word overruns
        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h022, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("t5_valid_held", 32'(vld[0]), 32'd1);
        check("t5_data_held", 32'(dw[0]), 32'h11);
        check_counts("t5");
        rdy[0] = 1'b1;
        pending[0] = 1'b0;
        wait_drain("t5_drained");
        repeat (3) @(negedge clk);
        check("t5_valid_cleared", 32'(vld[0]), 32'd0);

        // 6: reset mid-frame, on 8N1 and on 7O2
        reset_abort(0, 9'h081);
        reset_abort(2, 9'h041);

        // Randomised frames on every configuration
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 10; n++) begin
                rd = 9'($urandom);
                pf = (cfg_p(i) != 0) && ($urandom_range(0, 2) == 0);
                sb = ($urandom_range(0, 7) == 0);
                send_frame(i, rd, pf, sb);
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
            wait_drain($sformatf("rand_inst%0d_drained", i));
        end
        repeat (10) @(negedge clk);
        check_counts("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
